// File: rtl/exception_ctrl.sv
// exception_ctrl: MEM-stage exception prioritiser and flush/redirect sequencer feeding cp0_reg.
module exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int SYNC_STAGES = 2,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        inst_valid_i,
  input  logic [31:0] pc_i,
  input  logic        is_in_delayslot_i,
  input  logic        adel_if_i,
  input  logic        ri_i,
  input  logic        ov_i,
  input  logic        trap_i,
  input  logic        syscall_i,
  input  logic        break_i,
  input  logic        adel_mem_i,
  input  logic        ades_mem_i,
  input  logic        eret_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        cp0_we_i,
  input  logic [4:0]  cp0_waddr_i,
  input  logic [31:0] cp0_wdata_i,
  input  logic [5:0]  ext_int_i,
  input  logic        timer_int_i,
  output logic [5:0]  int_o,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic        newpc_valid_o,
  output logic [31:0] newpc_o
);
  typedef enum logic [1:0] {IDLE, COMMIT, DRAIN} state_t;
  state_t state_q;
  logic [SYNC_STAGES-1:0][5:0] sync_q;
  logic [3:0] cnt_q;
  logic int_pend;
  logic [31:0] exc_d, bad_d, newpc_d;
  logic unused;
  assign unused = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};
  assign int_o = {sync_q[SYNC_STAGES-1][5] | timer_int_i, sync_q[SYNC_STAGES-1][4:0]};
  always_comb begin
    int_pend = status_i[0] & ~status_i[1] & |(cause_i[15:8] & status_i[15:8]);
    exc_d = !inst_valid_i ? 32'h0 : int_pend ? 32'h1 : adel_if_i ? 32'h4 : ri_i ? 32'ha :
            ov_i ? 32'hc : trap_i ? 32'hd : syscall_i ? 32'h8 : break_i ? 32'h9 :
            adel_mem_i ? 32'h4 : ades_mem_i ? 32'h5 : eret_i ? 32'he : 32'h0;
    // code 4 is shared by fetch and load address errors; the fetch one outranks the load
    bad_d = exc_d == 32'h4 ? (adel_if_i ? pc_i : mem_addr_i) : exc_d == 32'h5 ? mem_addr_i : 32'h0;
    newpc_d = exc_d != 32'he ? EXC_VECTOR : (cp0_we_i && cp0_waddr_i == 5'd14) ? cp0_wdata_i : epc_i;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q <= '0;
      cnt_q <= '0;
      excepttype_o <= '0;
      current_inst_addr_o <= '0;
      is_in_delayslot_o <= 1'b0;
      bad_addr_o <= '0;
      flush_o <= 1'b0;
      newpc_valid_o <= 1'b0;
      newpc_o <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ext_int_i};
      excepttype_o <= '0;
      newpc_valid_o <= 1'b0;
      case (state_q)
        IDLE: if (exc_d != 32'h0 && !stall_i) begin
          state_q <= COMMIT;
          excepttype_o <= exc_d;
          current_inst_addr_o <= pc_i;
          is_in_delayslot_o <= is_in_delayslot_i;
          bad_addr_o <= bad_d;
          newpc_o <= newpc_d;
          flush_o <= 1'b1;
          newpc_valid_o <= 1'b1;
          cnt_q <= 4'd1;
        end
        COMMIT: begin
          state_q <= FLUSH_CYCLES > 1 ? DRAIN : IDLE;
          flush_o <= FLUSH_CYCLES > 1;
          cnt_q <= cnt_q + 4'd1;
        end
        DRAIN: if (cnt_q == 4'(FLUSH_CYCLES)) begin
          state_q <= IDLE;
          flush_o <= 1'b0;
        end else cnt_q <= cnt_q + 4'd1;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exception_ctrl.sv
// tb_exception_ctrl: directed bench comparing two flush lengths against a priority-list model.
module tb_exception_ctrl;
  logic clk = 0, rst = 1, stall = 0, valid = 0, ds = 0, timer = 0, we = 0;
  logic adel_if = 0, ri = 0, ov = 0, trap = 0, sys = 0, brk = 0, adel_mem = 0, ades_mem = 0, eret = 0;
  logic [31:0] pc = 0, mem_addr = 0, status = 0, cause = 0, epc = 0, wdata = 0;
  logic [4:0] waddr = 0;
  logic [5:0] ext = 0;
  logic [5:0] int_o [2];
  logic [31:0] exc_o [2], cia_o [2], bad_o [2], npc_o [2];
  logic ds_o [2], fl_o [2], nv_o [2];
  int checks = 0, errors = 0;
  int fl_len [2] = '{1, 3};
  int rem [2] = '{0, 0};
  logic [31:0] m_exc [2] = '{0, 0}, m_cia [2] = '{0, 0}, m_bad [2] = '{0, 0}, m_npc [2] = '{0, 0};
  logic m_ds [2] = '{0, 0}, m_fl [2] = '{0, 0}, m_nv [2] = '{0, 0};
  logic [5:0] hist [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    exception_ctrl #(.FLUSH_CYCLES(g == 0 ? 1 : 3)) u (
      .clk(clk), .rst(rst), .stall_i(stall), .inst_valid_i(valid), .pc_i(pc),
      .is_in_delayslot_i(ds), .adel_if_i(adel_if), .ri_i(ri), .ov_i(ov), .trap_i(trap),
      .syscall_i(sys), .break_i(brk), .adel_mem_i(adel_mem), .ades_mem_i(ades_mem),
      .eret_i(eret), .mem_addr_i(mem_addr), .status_i(status), .cause_i(cause), .epc_i(epc),
      .cp0_we_i(we), .cp0_waddr_i(waddr), .cp0_wdata_i(wdata), .ext_int_i(ext),
      .timer_int_i(timer), .int_o(int_o[g]), .excepttype_o(exc_o[g]),
      .current_inst_addr_o(cia_o[g]), .is_in_delayslot_o(ds_o[g]), .bad_addr_o(bad_o[g]),
      .flush_o(fl_o[g]), .newpc_valid_o(nv_o[g]), .newpc_o(npc_o[g]));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void detect(output logic [31:0] code, output logic [31:0] bad, output logic [31:0] npc);
    logic f [10];
    int codes [10];
    logic pend;
    codes = '{1, 4, 10, 12, 13, 8, 9, 4, 5, 14};
    pend = status[0] && !status[1] && ((cause[15:8] & status[15:8]) != 0);
    f = '{pend, adel_if, ri, ov, trap, sys, brk, adel_mem, ades_mem, eret};
    code = 0;
    bad = 0;
    if (valid)
      for (int i = 0; i < 10; i++)
        if (f[i] && code == 0) begin
          code = codes[i];
          bad = i == 1 ? pc : (i == 7 || i == 8) ? mem_addr : 32'h0;
        end
    npc = code == 14 ? ((we && waddr == 14) ? wdata : epc) : 32'hBFC00380;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [31:0] c, b, n;
    if (rst) begin
      hist.delete();
      for (int k = 0; k < 2; k++) begin
        rem[k] = 0; m_exc[k] = 0; m_cia[k] = 0; m_bad[k] = 0; m_npc[k] = 0;
        m_ds[k] = 0; m_fl[k] = 0; m_nv[k] = 0;
      end
    end else begin
      hist.push_back(ext);
      detect(c, b, n);
      for (int k = 0; k < 2; k++) begin
        m_exc[k] = 0;
        m_nv[k] = 0;
        if (rem[k] > 0) rem[k]--;
        else if (c != 0 && !stall) begin
          m_exc[k] = c; m_nv[k] = 1; m_cia[k] = pc; m_ds[k] = ds; m_bad[k] = b; m_npc[k] = n;
          rem[k] = fl_len[k];
        end
        m_fl[k] = rem[k] > 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [5:0] ei;
    ei = hist.size() >= 2 ? hist[hist.size()-2] : 6'd0;
    ei[5] = ei[5] | timer;
    for (int k = 0; k < 2; k++) begin
      chk("int_o", {26'd0, int_o[k]}, {26'd0, ei});
      chk("excepttype", exc_o[k], m_exc[k]);
      chk("inst_addr", cia_o[k], m_cia[k]);
      chk("delayslot", {31'd0, ds_o[k]}, {31'd0, m_ds[k]});
      chk("bad_addr", bad_o[k], m_bad[k]);
      chk("flush", {31'd0, fl_o[k]}, {31'd0, m_fl[k]});
      chk("newpc_valid", {31'd0, nv_o[k]}, {31'd0, m_nv[k]});
      chk("newpc", npc_o[k], m_npc[k]);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clr();
    {valid, stall, ds, adel_if, ri, ov, trap, sys, brk, adel_mem, ades_mem, eret, we} = '0;
  endtask

  initial begin
    step(3);
    chk("rst_exc", exc_o[0], 0);
    chk("rst_flush", {31'd0, fl_o[1]}, 0);
    chk("rst_npc", npc_o[0], 0);
    rst = 0;
    step(2);
    valid = 1; pc = 32'hBFC00100; sys = 1;
    step; clr();
    chk("sys_code", exc_o[0], 32'h8);
    chk("sys_flush", {31'd0, fl_o[0]}, 1);
    chk("sys_newpc", npc_o[0], 32'hBFC00380);
    chk("sys_nv", {31'd0, nv_o[0]}, 1);
    chk("sys_pc", cia_o[0], 32'hBFC00100);
    step;
    chk("sys_once", exc_o[0], 0);
    chk("sys_flush1_end", {31'd0, fl_o[0]}, 0);
    chk("sys_flush3_hold", {31'd0, fl_o[1]}, 1);
    chk("sys_npc_hold", npc_o[0], 32'hBFC00380);
    step(3);
    valid = 1; ades_mem = 1; mem_addr = 32'h80000003; ds = 1; stall = 1; pc = 32'h80001000;
    repeat (3) begin
      step;
      chk("stall_exc", exc_o[0], 0);
      chk("stall_flush", {31'd0, fl_o[0]}, 0);
    end
    stall = 0;
    step; clr();
    chk("ades_code", exc_o[0], 32'h5);
    chk("ades_bad", bad_o[0], 32'h80000003);
    chk("ades_ds", {31'd0, ds_o[0]}, 1);
    step(4);
    status = 32'h0000FF01; ext[2] = 1;
    step;
    chk("int_lat1", {31'd0, int_o[0][2]}, 0);
    step;
    chk("int_lat2", {31'd0, int_o[0][2]}, 1);
    cause = 32'h00001000; valid = 1; ov = 1;
    step; clr();
    chk("int_beats_ov", exc_o[0], 32'h1);
    step(4);
    status = 32'h0000FF03; valid = 1; ov = 1;
    step; clr();
    chk("exl_masks_int", exc_o[0], 32'hc);
    step(4);
    status = 0; cause = 0; ext = 0; timer = 1;
    step;
    chk("timer_int", {31'd0, int_o[1][5]}, 1);
    timer = 0;
    step(3);
    epc = 32'hDEAD0000; valid = 1; eret = 1; we = 1; waddr = 14; wdata = 32'h1234;
    step; clr();
    chk("eret_code", exc_o[0], 32'he);
    chk("eret_fwd_epc", npc_o[0], 32'h1234);
    step(4);
    valid = 1; eret = 1; we = 1; waddr = 13;
    step; clr();
    chk("eret_epc", npc_o[0], 32'hDEAD0000);
    step(4);
    valid = 1; pc = 32'h100; mem_addr = 32'h203; adel_if = 1; adel_mem = 1;
    step; clr();
    chk("adelif_code", exc_o[0], 32'h4);
    chk("adelif_bad", bad_o[0], 32'h100);
    step(4);
    valid = 1; ri = 1; ades_mem = 1;
    step; clr();
    chk("ri_code", exc_o[0], 32'ha);
    chk("ri_bad", bad_o[0], 0);
    step(4);
    sys = 1;
    step; clr();
    chk("bubble_exc", exc_o[0], 0);
    chk("bubble_flush", {31'd0, fl_o[0]}, 0);
    step(3);
    valid = 1; sys = 1; pc = 32'h400;
    step;
    chk("b2b_f1", {31'd0, fl_o[1]}, 1);
    chk("b2b_c1", exc_o[1], 32'h8);
    step;
    chk("b2b_f2", {31'd0, fl_o[1]}, 1);
    chk("b2b_c2", exc_o[1], 0);
    step; clr();
    chk("b2b_f3", {31'd0, fl_o[1]}, 1);
    chk("b2b_ignored", exc_o[1], 0);
    chk("b2b_short_again", exc_o[0], 32'h8);
    step;
    chk("b2b_f4", {31'd0, fl_o[1]}, 0);
    step(3);
    valid = 1; sys = 1; pc = 32'h500;
    step; clr();
    step;
    chk("drain_flush", {31'd0, fl_o[1]}, 1);
    #1 rst = 1;
    #1;
    chk("rst_drain_flush", {31'd0, fl_o[1]}, 0);
    chk("rst_drain_npc", npc_o[1], 0);
    chk("rst_drain_pc", cia_o[1], 0);
    step(2);
    rst = 0;
    step(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
